// File: rtl/sdr_types_pkg.sv
// Shared types for the SDR transmit chain.
//   Width macros : BIT_AXI_W (bitstream beat), IQ_W (one I/Q component),
//                  SYM_AXI_W (packed {I,Q} symbol beat).
//   iq_t         : signed Q1.15 complex sample.
//   pack_iq      : iq_t -> {I, Q} AXI-Stream word.
//   map_mode_t   : constellation selector for sym_mapper.
//   map_state_t  : sym_mapper output FSM states.
`ifndef BIT_AXI_W
`define BIT_AXI_W 8
`endif
`ifndef IQ_W
`define IQ_W 16
`endif
`ifndef SYM_AXI_W
`define SYM_AXI_W 32
`endif

package sdr_types_pkg;

  typedef struct packed {
    logic signed [`IQ_W-1:0] i;
    logic signed [`IQ_W-1:0] q;
  } iq_t;

  typedef enum logic {MAP_BPSK = 1'b0, MAP_QPSK = 1'b1} map_mode_t;

  typedef enum logic {ST_EMPTY = 1'b0, ST_EMIT = 1'b1} map_state_t;

  localparam logic signed [`IQ_W-1:0] BPSK_AMP_DEF = 16'sd32767;
  localparam logic signed [`IQ_W-1:0] QPSK_AMP_DEF = 16'sd23170;

  function automatic logic [`SYM_AXI_W-1:0] pack_iq(input iq_t s);
    return {s.i, s.q};
  endfunction

endpackage

// File: rtl/sym_mapper_lut.sv
// Combinational constellation lookup.
//   mode : MAP_BPSK or MAP_QPSK
//   bits : bits[1] is the first (MSB-side) bit, bits[0] the second;
//          bits[0] is ignored in BPSK.
//   iq   : mapped symbol. Bit 0 -> +AMP, bit 1 -> -AMP. BPSK puts the
//          symbol on I with Q = 0; QPSK (Gray) puts bits[1] on I and
//          bits[0] on Q.
module sym_mapper_lut
  import sdr_types_pkg::*;
#(
  parameter int                      IQ_W     = `IQ_W,
  parameter logic signed [IQ_W-1:0]  BPSK_AMP = BPSK_AMP_DEF,
  parameter logic signed [IQ_W-1:0]  QPSK_AMP = QPSK_AMP_DEF
) (
  input  map_mode_t   mode,
  input  logic [1:0]  bits,
  output iq_t         iq
);

  // Amplitudes are strictly below full scale, so negation cannot overflow.
  function automatic logic signed [IQ_W-1:0] bit_to_amp(
    input logic signed [IQ_W-1:0] amp,
    input logic                   b
  );
    return b ? -amp : amp;
  endfunction

  always_comb begin
    iq = '0;
    if (mode == MAP_QPSK) begin
      iq.i = bit_to_amp(QPSK_AMP, bits[1]);
      iq.q = bit_to_amp(QPSK_AMP, bits[0]);
    end else begin
      iq.i = bit_to_amp(BPSK_AMP, bits[1]);
      iq.q = '0;
    end
  end

endmodule

// File: rtl/sym_mapper.sv
// Constellation mapper: bytes in, Q1.15 complex symbols out, MSB-first.
//   clk, rst              : clock, synchronous active-high reset
//   mode                  : 0 = BPSK (8 symbols/byte), 1 = QPSK (4 symbols/byte),
//                           sampled when a byte is accepted
//   s_tdata/s_tvalid/s_tready/s_tlast : byte stream input
//   m_tdata/m_tvalid/m_tready/m_tlast/m_tkeep : {I,Q} symbol stream output
//   sym_count             : symbols handed off since reset (wraps)
module sym_mapper
  import sdr_types_pkg::*;
#(
  parameter int                      IQ_W     = `IQ_W,
  parameter logic signed [IQ_W-1:0]  BPSK_AMP = BPSK_AMP_DEF,
  parameter logic signed [IQ_W-1:0]  QPSK_AMP = QPSK_AMP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [`BIT_AXI_W-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic [`SYM_AXI_W-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic [3:0]             m_tkeep,
  output logic [31:0]            sym_count
);

  map_state_t                state_p0, state_nxt;
  logic [`BIT_AXI_W-1:0]     sr_p0;      // unsent bits, next symbol at the MSBs
  logic [2:0]                cnt_p0;     // symbols remaining after the current one
  map_mode_t                 mode_p0;    // mode latched with the held byte
  logic                      last_p0;    // tlast latched with the held byte
  logic [`SYM_AXI_W-1:0]     data_p0;

  logic       m_hs;
  logic       accept;
  logic       advance;
  map_mode_t  lut_mode;
  logic [1:0] lut_bits;
  iq_t        lut_iq;

  // s_tready depends only on registered state and m_tready, never s_tvalid.
  assign m_tvalid = (state_p0 == ST_EMIT);
  assign s_tready = (state_p0 == ST_EMPTY) || (m_tready && (cnt_p0 == 3'd0));
  assign m_hs     = m_tvalid && m_tready;
  assign accept   = s_tvalid && s_tready;
  assign advance  = m_hs && (cnt_p0 != 3'd0);

  assign m_tdata  = data_p0;
  assign m_tlast  = m_tvalid && last_p0 && (cnt_p0 == 3'd0);
  assign m_tkeep  = 4'hF;

  // A fresh byte maps its own top bits; otherwise map the shift register.
  assign lut_mode = accept ? map_mode_t'(mode) : mode_p0;
  assign lut_bits = accept ? s_tdata[`BIT_AXI_W-1 -: 2] : sr_p0[`BIT_AXI_W-1 -: 2];

  sym_mapper_lut #(
    .IQ_W     (IQ_W),
    .BPSK_AMP (BPSK_AMP),
    .QPSK_AMP (QPSK_AMP)
  ) u_lut (
    .mode (lut_mode),
    .bits (lut_bits),
    .iq   (lut_iq)
  );

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_EMPTY: if (accept) state_nxt = ST_EMIT;
      // Final symbol leaving: refill in the same cycle if a byte is waiting.
      ST_EMIT:  if (m_hs && (cnt_p0 == 3'd0)) state_nxt = accept ? ST_EMIT : ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // ---- stage p0: output register, shift register and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= ST_EMPTY;
      sr_p0     <= '0;
      cnt_p0    <= 3'd0;
      mode_p0   <= MAP_BPSK;
      last_p0   <= 1'b0;
      data_p0   <= '0;
      sym_count <= 32'd0;
    end else begin
      state_p0 <= state_nxt;
      if (m_hs) sym_count <= sym_count + 32'd1;
      if (accept) begin
        data_p0 <= pack_iq(lut_iq);
        mode_p0 <= map_mode_t'(mode);
        last_p0 <= s_tlast;
        if (map_mode_t'(mode) == MAP_QPSK) begin
          sr_p0  <= {s_tdata[`BIT_AXI_W-3:0], 2'b00};
          cnt_p0 <= 3'd3;
        end else begin
          sr_p0  <= {s_tdata[`BIT_AXI_W-2:0], 1'b0};
          cnt_p0 <= 3'd7;
        end
      end else if (advance) begin
        data_p0 <= pack_iq(lut_iq);
        cnt_p0  <= cnt_p0 - 3'd1;
        if (mode_p0 == MAP_QPSK) sr_p0 <= {sr_p0[`BIT_AXI_W-3:0], 2'b00};
        else                     sr_p0 <= {sr_p0[`BIT_AXI_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_sym_mapper.sv
module tb_sym_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [3:0]  m_tkeep;
  logic [31:0] sym_count;

  int checks = 0;
  int errors = 0;
  int tlast_seen = 0;
  bit bp_done = 1'b0;
  logic [32:0] sbq[$];   // {tdata, tlast}

  sym_mapper dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .m_tkeep   (m_tkeep),
    .sym_count (sym_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: expected symbols for one accepted byte.
  function automatic void push_byte(input logic [7:0] b, input logic md, input logic lst);
    logic [15:0] iv, qv;
    if (md) begin
      for (int k = 0; k < 4; k++) begin
        iv = b[7-2*k] ? 16'hA57E : 16'h5A82;
        qv = b[6-2*k] ? 16'hA57E : 16'h5A82;
        sbq.push_back({iv, qv, lst && (k == 3)});
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        iv = b[7-k] ? 16'h8001 : 16'h7FFF;
        sbq.push_back({iv, 16'h0000, lst && (k == 7)});
      end
    end
  endfunction

  // Scoreboard monitor: pushes on byte acceptance, pops on symbol handoff.
  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] exp_sym;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: got tvalid=%b tdata=%h tlast=%b, want tvalid=1 tdata=%h tlast=%b",
                     m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
          end
        end
        if (m_tvalid && m_tready) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_symbol: got tdata=%h tlast=%b, want no symbol", m_tdata, m_tlast);
          end else begin
            exp_sym = sbq.pop_front();
            if ({m_tdata, m_tlast} !== exp_sym) begin
              errors++;
              $display("FAIL symbol: got tdata=%h tlast=%b, want tdata=%h tlast=%b",
                       m_tdata, m_tlast, exp_sym[32:1], exp_sym[0]);
            end
          end
          if (m_tlast) tlast_seen++;
        end
        if (s_tvalid && s_tready) push_byte(s_tdata, mode, s_tlast);
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic md, input logic lst);
    int n;
    s_tdata  = d;
    mode     = md;
    s_tlast  = lst;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_tready=%b, want 1", s_tready);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || m_tvalid) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0 || m_tvalid) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending symbols tvalid=%b, want 0 pending tvalid=0",
               name, sbq.size(), m_tvalid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h tlast=%b, want 0 0 0", m_tvalid, m_tdata, m_tlast);
    end
    checks++;
    if (sym_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_sym_count: got %0d, want 0", sym_count);
    end
    checks++;
    if (s_tready !== 1'b1 || m_tkeep !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready_keep: got s_tready=%b tkeep=%h, want 1 f", s_tready, m_tkeep);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bpsk();
    m_tready = 1'b1;
    send_byte(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin
        errors++;
        $display("FAIL bpsk_busy[%0d]: got s_tready=%b tvalid=%b, want 0 1", i, s_tready, m_tvalid);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1 || m_tdata !== 32'h80010000) begin
      errors++;
      $display("FAIL bpsk_last: got s_tready=%b tdata=%h, want 1 80010000", s_tready, m_tdata);
    end
    wait_drain("bpsk");
  endtask

  task automatic test_qpsk();
    logic [31:0] exp_q [4];
    exp_q = '{32'h5A825A82, 32'h5A82A57E, 32'hA57E5A82, 32'hA57EA57E};
    m_tready = 1'b1;
    send_byte(8'h1B, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== exp_q[i]) begin
        errors++;
        $display("FAIL qpsk_beat[%0d]: got tvalid=%b tdata=%h, want 1 %h", i, m_tvalid, m_tdata, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
    wait_drain("qpsk");
  endtask

  task automatic test_back_to_back();
    logic want_rdy;
    m_tready = 1'b1;
    mode     = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b1;
    @(posedge clk);   // EMPTY: first byte accepted here
    #1;
    s_tdata = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      want_rdy = (i == 3) || (i == 7);
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || s_tready !== want_rdy) begin
        errors++;
        $display("FAIL b2b_beat[%0d]: got tvalid=%b s_tready=%b, want 1 %b", i, m_tvalid, s_tready, want_rdy);
      end
      @(posedge clk);
      #1;
      if (i == 3) s_tvalid = 1'b0;
    end
    wait_drain("b2b");
  endtask

  task automatic test_packet();
    int t0;
    t0 = tlast_seen;
    m_tready = 1'b1;
    send_byte(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mode = ~mode;
      @(posedge clk);
      #1;
    end
    send_byte(8'hC3, 1'b0, 1'b1);
    wait_drain("packet");
    checks++;
    if (tlast_seen - t0 != 1) begin
      errors++;
      $display("FAIL packet_tlast_count: got %0d, want 1", tlast_seen - t0);
    end
    checks++;
    if (sym_count !== 32'd36) begin
      errors++;
      $display("FAIL packet_sym_count: got %0d, want 36", sym_count);
    end
    send_byte(8'h6C, 1'b1, 1'b0);
    wait_drain("mode_switch");
    checks++;
    if (sym_count !== 32'd40) begin
      errors++;
      $display("FAIL mode_switch_sym_count: got %0d, want 40", sym_count);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    m_tready = 1'b1;
    send_byte(8'h1B, 1'b1, 1'b1);
    @(posedge clk);   // symbol 1 handed off
    #1;
    @(posedge clk);   // symbol 2 handed off
    #1;
    t0 = tlast_seen;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || sym_count !== 32'd0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_state: got tvalid=%b sym_count=%0d s_tready=%b, want 0 0 1",
               m_tvalid, sym_count, s_tready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b0 || tlast_seen != t0) begin
        errors++;
        $display("FAIL midreset_quiet[%0d]: got tvalid=%b tlasts=%0d, want 0 %0d", i, m_tvalid, tlast_seen, t0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bp_done = 1'b0;
    fork
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 256; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        wait_drain("backpressure");
        bp_done = 1'b1;
      end
    join
    m_tready = 1'b1;
    checks++;
    if (sym_count !== 32'd2048) begin
      errors++;
      $display("FAIL backpressure_sym_count: got %0d, want 2048", sym_count);
    end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qpsk();
    test_back_to_back();
    test_packet();
    test_reset_mid();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_mapper.md
# sym_mapper

Constellation mapper between the bitstream leg and the symbol leg of the SDR transmit chain. It accepts 8-bit AXI-Stream bytes from the scrambler/FEC output and emits Q1.15 complex symbols as 32-bit AXI-Stream beats {I[15:0], Q[15:0]}. Each symbol carries one bit (BPSK) or two bits (QPSK), taken MSB-first. Output feeds the pulse-shaping filter.

## Interface
- IQ_W, 16, bits per I/Q component (signed Q1.15).
- BPSK_AMP, 16'sd32767, BPSK magnitude.
- QPSK_AMP, 16'sd23170, QPSK per-axis magnitude (≈0.7071).
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only on byte acceptance.
- s_tdata  in  8  input byte.
- s_tvalid  in  1  byte valid.
- s_tready  out  1  byte accepted when s_tvalid && s_tready.
- s_tlast  in  1  last byte of packet.
- m_tdata  out  32  {I, Q}.
- m_tvalid  out  1  symbol valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  last symbol of packet.
- m_tkeep  out  4  constant 4'hF.
- sym_count  out  32  symbols handed off since reset; wraps at 2^32.

## Operation
- States: EMPTY (no byte held, m_tvalid=0), EMIT (byte held, m_tvalid=1).
- Byte accept loads: first symbol into output register, remaining bits into shift register `sr`, `cnt` = symbols remaining after current (BPSK 7, QPSK 3), latched mode, latched tlast.
- Bit mapping: bit 0 → +AMP, bit 1 → −AMP (two's complement of AMP, e.g. −32767 = 16'h8001).
- BPSK: I = map(b), Q = 0.
- QPSK (Gray): first bit of pair → I, second → Q.
- On m handshake with cnt>0: next symbol from `sr`, shift, cnt−1.
- On m handshake with cnt==0: if s_tvalid, accept new byte the same cycle (stay EMIT); otherwise go EMPTY.
- s_tready = (state==EMPTY) || (m_tready && cnt==0). Combinational from registered state and m_tready only; no s_tvalid→s_tready path.
- m_tlast = latched tlast && cnt==0. Asserted only on the final symbol of a tlast byte.
- mode changes while EMIT do not affect the held byte.
- m_tvalid low → m_tdata/m_tlast are don't-care. m_tvalid high and m_tready low → m_tdata, m_tlast, and cnt hold stable.
- sym_count increments by 1 on every m_tvalid && m_tready.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, sym_count=0, state=EMPTY, cnt=0, sr=0. s_tready=1 the cycle after reset deasserts.
- Latency: byte accepted at edge N → first symbol valid after edge N (visible in cycle N+1).
- Throughput with m_tready held high: one symbol per clock, no bubbles between bytes.
  - BPSK consumes one byte per 8 cycles.
  - QPSK consumes one byte per 4 cycles.
- rst asserted mid-byte discards the held byte and the remaining symbols. No partial tlast is emitted.
- A new byte and the final symbol's handoff in the same cycle: both occur; sym_count increments once.

## Structure
- Add to sdr_types_pkg: `typedef enum logic {MAP_BPSK=1'b0, MAP_QPSK=1'b1} map_mode_t`, plus localparams BPSK_AMP_DEF and QPSK_AMP_DEF.
- Reuse the existing iq_t and pack_iq for output packing.
- Use the global BIT_AXI_W, IQ_W and SYM_AXI_W width macros.
- One combinational sub-module, `sym_mapper_lut`: inputs (mode, 2 bits), output iq_t. The top holds the FSM, shift register, counters and output register.

## Test plan
- BPSK, byte 0xA5, m_tready=1 → I sequence 8001,7FFF,8001,7FFF,7FFF,8001,7FFF,8001 with Q=0 on all eight; s_tready low for 7 cycles.
- QPSK, byte 0x1B → beats 5A825A82, 5A82A57E, A57E5A82, A57EA57E on 4 consecutive cycles.
- QPSK, back-to-back bytes 0x00, 0xFF with s_tvalid held → 8 contiguous beats with no bubble; second byte accepted on the cycle the 4th symbol hands off.
- Random m_tready backpressure (50%) over 256 BPSK bytes → output stable while stalled; decoded bits equal input; sym_count=2048.
- BPSK, packet of 2 bytes with tlast on the second → m_tlast high only on symbol 16. Toggling mode during the packet has no effect until the next byte is accepted.
- rst pulsed after the 2nd QPSK symbol → next cycle m_tvalid=0, sym_count=0, s_tready=1; no remaining symbols emitted.
